// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and data memory (slave).
// The master issues a request with lane-aligned write data and a byte mask. The slave
// answers with an ack, and read data is valid in the same cycle as that ack.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine. It takes one load or store from the EX/MEM register and
// runs a req/ack handshake to data memory. It lane-aligns, masks and extends the data,
// and holds the pipeline through stall_o until the access finishes.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap accesses that are not size-aligned
// (cause 10 for loads, 11 for stores). In that case no bus request is issued.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] rdata_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  mem_access_unit_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [1:0]       cause_q, cause_d;

  logic [63:0]      shiftedRd;
  logic [63:0]      loadExt;
  logic [63:0]      wdataLane;
  logic [7:0]       sizeMask;
  logic [7:0]       wmaskLane;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [2:0]       alignMask;
  logic             misaligned;

  // An incoming access is misaligned when any address bit below its size is set
  always_comb begin
    alignMask = 3'b000;
    case (req_funct3_i[1:0])
      2'b00:   alignMask = 3'b000;
      2'b01:   alignMask = 3'b001;
      2'b10:   alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
    misaligned = |(req_addr_i[2:0] & alignMask);
  end
`endif

  // State and captured-request registers; reset puts everything back to idle with zeroed outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      cause_q  <= cause_d;
    end
  end

  // Lane steering: shift read data down to bit 0 and extend it, and shift store data and mask up into their byte lanes
  always_comb begin
    shiftedRd = mem.mem_rdata >> {addr_q[2:0], 3'b000};
    case (funct3_q)
      3'b000:  loadExt = {{56{shiftedRd[7]}},  shiftedRd[7:0]};
      3'b001:  loadExt = {{48{shiftedRd[15]}}, shiftedRd[15:0]};
      3'b010:  loadExt = {{32{shiftedRd[31]}}, shiftedRd[31:0]};
      3'b100:  loadExt = {56'd0, shiftedRd[7:0]};
      3'b101:  loadExt = {48'd0, shiftedRd[15:0]};
      3'b110:  loadExt = {32'd0, shiftedRd[31:0]};
      default: loadExt = shiftedRd;
    endcase
    case (funct3_q[1:0])
      2'b00:   sizeMask = 8'h01;
      2'b01:   sizeMask = 8'h03;
      2'b10:   sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
    wdataLane = wdata_q << {addr_q[2:0], 3'b000};
    wmaskLane = sizeMask << addr_q[2:0];
  end

  // Next-state logic: a flush during REQ sets the kill flag, but the bus transaction still runs to ack or timeout
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    cause_d  = cause_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          cnt_d    = '0;
          kill_d   = 1'b0;
          state_d  = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = FAULT;
            cause_d = req_we_i ? 2'b11 : 2'b10;
          end
`endif
        end
      end
      REQ: begin
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (mem.mem_ack) begin
          rdata_d = we_q ? 64'd0 : loadExt;
          state_d = (kill_q || flush_i) ? IDLE : DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (kill_q || flush_i) begin
            state_d = IDLE;
          end else begin
            state_d = FAULT;
            cause_d = 2'b01;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: bus signals are driven only in REQ, and stall is combinational so the stage holds from the first cycle
  always_comb begin
    stall_o       = 1'b0;
    done_o        = 1'b0;
    fault_o       = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 64'd0;
    mem.mem_wdata = 64'd0;
    mem.mem_wmask = 8'h00;
    case (state_q)
      IDLE: stall_o = req_valid_i && !flush_i && !rst;
      REQ: begin
        stall_o       = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = {addr_q[63:3], 3'b000};
        mem.mem_wdata = wdataLane;
        mem.mem_wmask = we_q ? wmaskLane : 8'h00;
      end
      DONE:    done_o  = !flush_i;
      default: fault_o = !flush_i;
    endcase
    rdata_o       = rdata_q;
    fault_cause_o = cause_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. It runs directed cases followed by randomized
// loads and stores, each checked against a behavioural model of the access rules.
// Expectations follow MEM_MISALIGN_TRAP_EN in the same way as the design.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWe;
  logic [2:0]  reqFunct3;
  logic [63:0] reqAddr;
  logic [63:0] reqWdata;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        fault;
  logic [1:0]  faultCause;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  lastCause;
  logic [63:0] lastRdata;
  logic [63:0] lastBusAddr;
  logic [63:0] lastBusWdata;
  logic [7:0]  lastBusMask;
  int          lastReqCycles;

  mem_access_unit_if memIf ();

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (reqValid),
    .req_we_i      (reqWe),
    .req_funct3_i  (reqFunct3),
    .req_addr_i    (reqAddr),
    .req_wdata_i   (reqWdata),
    .flush_i       (flush),
    .stall_o       (stall),
    .done_o        (done),
    .rdata_o       (rdata),
    .fault_o       (fault),
    .fault_cause_o (faultCause),
    .mem           (memIf)
  );

  always #5 clk = ~clk;

  // Reference model: load result from the bus doubleword, byte offset and funct3
  function automatic logic [63:0] modelLoad(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] bus);
    int          nBits;
    logic [63:0] x;
    logic [63:0] m;
    x = bus >> (8 * int'(off));
    nBits = 8 * (1 << f3[1:0]);
    if (nBits == 64) return x;
    m = (64'd1 << nBits) - 64'd1;
    x = x & m;
    if (!f3[2] && x[nBits-1]) x = x | ~m;
    return x;
  endfunction

  // Reference model: store byte mask, truncated at the doubleword boundary
  function automatic logic [7:0] modelMask(input logic [2:0] f3, input logic [2:0] off);
    int tmp;
    tmp = ((1 << (1 << f3[1:0])) - 1) << int'(off);
    return 8'(tmp);
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic bit modelMisaligned(input logic [2:0] f3, input logic [63:0] addr);
    return (int'(addr[2:0]) % (1 << f3[1:0])) != 0;
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wd, input logic fl);
    reqValid  = v;
    reqWe     = we;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wd;
    flush     = fl;
  endtask

  // One full access: ackAt is the REQ cycle (0-based) carrying the ack, -1 for none;
  // flushAt is the REQ cycle in which flush is pulsed, -1 for none.
  task automatic runAccess(input string name, input logic we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd, input int ackAt,
                           input logic [63:0] busData, input int flushAt);
    bit acked;
    bit killed;
    acked = 1'b0;
    killed = 1'b0;
    lastReqCycles = 0;
    @(negedge clk);
    applyStimulus(1'b1, we, f3, addr, wd, 1'b0);
    #1;
    checkOutput({name, " idle stall"}, 64'(stall), 64'd1);
    checkOutput({name, " idle mem_req"}, 64'(memIf.mem_req), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    if (modelMisaligned(f3, addr)) begin
      @(negedge clk);
      reqValid = 1'b0;
      #1;
      lastCause = we ? 2'b11 : 2'b10;
      checkOutput({name, " trap fault"}, 64'(fault), 64'd1);
      checkOutput({name, " trap cause"}, 64'(faultCause), 64'(lastCause));
      checkOutput({name, " trap mem_req"}, 64'(memIf.mem_req), 64'd0);
      checkOutput({name, " trap done"}, 64'(done), 64'd0);
      return;
    end
`endif
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      flush = (k == flushAt);
      memIf.mem_ack = (k == ackAt);
      memIf.mem_rdata = (k == ackAt) ? busData : {$urandom, $urandom};
      #1;
      if (k == flushAt) killed = 1'b1;
      lastReqCycles++;
      checkOutput({name, " req mem_req"}, 64'(memIf.mem_req), 64'd1);
      checkOutput({name, " req stall"}, 64'(stall), 64'd1);
      checkOutput({name, " req done"}, 64'(done | fault), 64'd0);
      if (k == 0) begin
        lastBusAddr  = memIf.mem_addr;
        lastBusWdata = memIf.mem_wdata;
        lastBusMask  = memIf.mem_wmask;
        checkOutput({name, " bus addr"}, memIf.mem_addr, {addr[63:3], 3'b000});
        checkOutput({name, " bus we"}, 64'(memIf.mem_we), 64'(we));
        checkOutput({name, " bus mask"}, 64'(memIf.mem_wmask),
                    we ? 64'(modelMask(f3, addr[2:0])) : 64'd0);
        if (we) checkOutput({name, " bus wdata"}, memIf.mem_wdata, wd << (8 * int'(addr[2:0])));
      end
      if (k == ackAt) begin
        acked = 1'b1;
        break;
      end
    end
    @(negedge clk);
    reqValid = 1'b0;
    flush = 1'b0;
    memIf.mem_ack = 1'b0;
    #1;
    checkOutput({name, " end mem_req"}, 64'(memIf.mem_req), 64'd0);
    checkOutput({name, " end stall"}, 64'(stall), 64'd0);
    if (killed) begin
      checkOutput({name, " killed done"}, 64'(done), 64'd0);
      checkOutput({name, " killed fault"}, 64'(fault), 64'd0);
    end else if (acked) begin
      lastRdata = rdata;
      checkOutput({name, " done"}, 64'(done), 64'd1);
      checkOutput({name, " fault"}, 64'(fault), 64'd0);
      checkOutput({name, " rdata"}, rdata, we ? 64'd0 : modelLoad(f3, addr[2:0], busData));
    end else begin
      lastCause = 2'b01;
      checkOutput({name, " timeout fault"}, 64'(fault), 64'd1);
      checkOutput({name, " timeout done"}, 64'(done), 64'd0);
    end
    checkOutput({name, " cause"}, 64'(faultCause), 64'(lastCause));
  endtask

  initial begin
    logic        rWe;
    logic [2:0]  rF3;
    int          rAck;
    int          rFlush;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    memIf.mem_ack = 1'b0;
    memIf.mem_rdata = 64'd0;
    lastCause = 2'b00;
    #1;
    checkOutput("reset mem_req", 64'(memIf.mem_req), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset fault", 64'(fault), 64'd0);
    checkOutput("reset rdata", rdata, 64'd0);
    checkOutput("reset cause", 64'(faultCause), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Test 1: lw at 0x1004, ack in the third REQ cycle, sign bit set in upper word
    runAccess("t1 lw", 1'b0, 3'b010, 64'h1004, 64'd0, 2, 64'h80000000_00000000, -1);
    checkOutput("t1 addr const", lastBusAddr, 64'h1000);
    checkOutput("t1 rdata const", lastRdata, 64'hFFFFFFFF_80000000);

    // Test 2: sb at 0x2003
    runAccess("t2 sb", 1'b1, 3'b000, 64'h2003, 64'hAB, 0, 64'h0, -1);
    checkOutput("t2 mask const", 64'(lastBusMask), 64'h08);
    checkOutput("t2 wdata const", lastBusWdata, 64'hAB000000);
    checkOutput("t2 rdata const", lastRdata, 64'd0);

    // Test 3: ld with no ack times out
    runAccess("t3 ld timeout", 1'b0, 3'b011, 64'h4000, 64'd0, -1, 64'd0, -1);
    checkOutput("t3 req cycles", 64'(lastReqCycles), 64'(TIMEOUT));
    checkOutput("t3 cause const", 64'(faultCause), 64'd1);

    // Test 4: flush in REQ cycle 2, ack in cycle 4
    runAccess("t4 flush", 1'b0, 3'b011, 64'h5000, 64'd0, 3, 64'h1234, 1);

    // Test 5: lh at 0x3001 (trapped or completed depending on build)
    runAccess("t5 lh", 1'b0, 3'b001, 64'h3001, 64'd0, 0, 64'h00000000_00C3B200, -1);
`ifndef MEM_MISALIGN_TRAP_EN
    checkOutput("t5 rdata const", lastRdata, 64'hFFFFFFFF_FFFFC3B2);
`endif

    // Ack while idle is ignored
    @(negedge clk);
    memIf.mem_ack = 1'b1;
    memIf.mem_rdata = 64'hDEAD;
    #1;
    checkOutput("idle ack mem_req", 64'(memIf.mem_req), 64'd0);
    @(negedge clk);
    memIf.mem_ack = 1'b0;
    #1;
    checkOutput("idle ack done", 64'(done), 64'd0);

    // Flush in IDLE: no request issued
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h6000, 64'd0, 1'b1);
    #1;
    checkOutput("idle flush stall", 64'(stall), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    #1;
    checkOutput("idle flush mem_req", 64'(memIf.mem_req), 64'd0);

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      rWe = 1'($urandom_range(0, 1));
      rF3 = rWe ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      rAck = $urandom_range(0, 19);
      if (rAck >= TIMEOUT) rAck = -1;
      rFlush = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT - 1) : -1;
      runAccess($sformatf("rnd%0d", i), rWe, rF3, {$urandom, $urandom}, {$urandom, $urandom},
                rAck, {$urandom, $urandom}, rFlush);
    end

    // Test 6: reset mid-REQ, later ack ignored
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h7000, 64'd0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t6 in req", 64'(memIf.mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 rst mem_req", 64'(memIf.mem_req), 64'd0);
    checkOutput("t6 rst stall", 64'(stall), 64'd0);
    checkOutput("t6 rst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    reqValid = 1'b0;
    memIf.mem_ack = 1'b1;
    memIf.mem_rdata = 64'hFFFF;
    #1;
    checkOutput("t6 late ack mem_req", 64'(memIf.mem_req), 64'd0);
    @(negedge clk);
    memIf.mem_ack = 1'b0;
    #1;
    checkOutput("t6 late ack done", 64'(done), 64'd0);
    checkOutput("t6 late ack stall", 64'(stall), 64'd0);
    checkOutput("t6 rdata cleared", rdata, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
